// File: rtl/aesl_deadlock_report_arbiter.sv
// ---------------------------------------------------------------------------
// aesl_deadlock_report_arbiter
//
// Purpose:
//   Collects the block flags of the per-instance deadlock monitors in the
//   co-simulation testbench. Each flag only counts while its instance is not
//   idle, and it must persist for THRESH consecutive cycles before it is
//   confirmed. Confirmed deadlocks are latched as pending and are then sent,
//   one at a time in round-robin order, over a valid/ready report channel.
//   A single registered global block flag summarises the arbiter state.
//
// Optional feature (compile-time macro):
//   AESL_DEADLOCK_TIMESTAMP_EN - builds a 32-bit free-running cycle counter.
//     report_time is loaded from it when a report is launched. Without the
//     macro the counter is not built and report_time stays 0.
//
// Ports:
//   clock         in   1        single clock, all logic on posedge
//   reset         in   1        synchronous, active-high
//   mon_block     in   NUM_MON  block output of each sub-monitor
//   mon_idle      in   NUM_MON  idle flag of the instance each monitor watches
//   report_ready  in   1        consumer accepts the current report
//   report_valid  out  1        a confirmed deadlock report is presented
//   report_idx    out  IDX_W    index of the reported monitor
//   report_time   out  32       cycle stamp of the report (0 without timestamps)
//   block         out  1        OR of all pending confirmations and the active report
// ---------------------------------------------------------------------------
module aesl_deadlock_report_arbiter #(
    parameter int NUM_MON = 4,
    parameter int IDX_W   = 2,
    parameter int THRESH  = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic [NUM_MON-1:0] mon_idle,
    input  logic               report_ready,
    output logic               report_valid,
    output logic [IDX_W-1:0]   report_idx,
    output logic [31:0]        report_time,
    output logic               block
);

    typedef enum logic {
        S_IDLE,
        S_REPORT
    } state_t;

    localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] THRESH_M1   = CNT_W'(THRESH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_MON - 1);
    localparam logic [IDX_W:0]   NUM_MON_EXT = (IDX_W + 1)'(NUM_MON);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_MON-1:0] pending;
    logic [NUM_MON-1:0] pending_nxt;
    logic [NUM_MON-1:0] qual;
    logic [NUM_MON-1:0] confirm;
    logic [NUM_MON-1:0] clear;
    logic [CNT_W-1:0]   cnt [NUM_MON];
    logic               handshake;
    logic               valid_nxt;
    logic [IDX_W-1:0]   winner;
    logic [31:0]        ts_now;

    // A monitor's block flag is meaningless while its instance is idle.
    assign qual      = mon_block & ~mon_idle;
    assign handshake = (state == S_REPORT) && report_ready;

    // Value report_valid will take after the coming edge; lets the registered
    // block flag line up with the pending/report state it summarises.
    assign valid_nxt = (state == S_IDLE) ? (|pending) : ~report_ready;

    // -----------------------------------------------------------------------
    // Cycle stamp source
    // -----------------------------------------------------------------------
`ifdef AESL_DEADLOCK_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign ts_now = cycle_cnt;
`else
    assign ts_now = '0;
`endif

    // -----------------------------------------------------------------------
    // Persistence counters: count qualified cycles, saturate at THRESH and
    // clear as soon as the qualified flag drops (this is the re-arm path).
    // -----------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every always_ff
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_MON; i++) begin
            if (reset) begin
                cnt[i] <= '0;
            end else if (!qual[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] != THRESH_C) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Confirm fires only on the THRESH-1 -> THRESH step, so a saturated
    // counter can never confirm a second time. The handshake clear of the
    // reported index takes priority over any confirm of that index.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        confirm = '0;
        clear   = '0;
        for (int i = 0; i < NUM_MON; i++) begin
            confirm[i] = qual[i] && (cnt[i] == THRESH_M1);
            clear[i]   = handshake && (report_idx == IDX_W'(i));
        end
        pending_nxt = (pending | confirm) & ~clear;
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: first pending index at or after rr_ptr, wrapping.
    // -----------------------------------------------------------------------
    always_comb begin
        logic [IDX_W:0] cand;
        logic           found;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int j = 0; j < NUM_MON; j++) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(j);
            if (cand >= NUM_MON_EXT) begin
                cand = cand - NUM_MON_EXT;
            end
            for (int i = 0; i < NUM_MON; i++) begin
                if (!found && pending[i] && (cand == (IDX_W + 1)'(i))) begin
                    found  = 1'b1;
                    winner = IDX_W'(i);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Report FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            pending      <= '0;
            report_valid <= 1'b0;
            report_idx   <= '0;
            report_time  <= '0;
            block        <= 1'b0;
        end else begin
            pending <= pending_nxt;
            block   <= (|pending_nxt) | valid_nxt;
            case (state)
                S_IDLE: begin
                    if (|pending) begin
                        report_idx   <= winner;
                        report_time  <= ts_now;
                        report_valid <= 1'b1;
                        state        <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    // Outputs hold until the consumer takes the report.
                    if (report_ready) begin
                        report_valid <= 1'b0;
                        rr_ptr       <= (report_idx == LAST_IDX) ? '0 : report_idx + 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aesl_deadlock_report_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aesl_deadlock_report_arbiter
//
// Directed bench for aesl_deadlock_report_arbiter with THRESH=4, NUM_MON=4.
// A table of {inputs, expected outputs} rows covers reset, single confirm,
// short bursts, idle masking, simultaneous confirms with round-robin order
// and re-arm. Hand-written sequences cover the report-hold, reset in the
// middle of a report and the cycle stamp.
// ---------------------------------------------------------------------------
module tb_aesl_deadlock_report_arbiter;

    localparam int NUM_MON = 4;
    localparam int IDX_W   = 2;
    localparam int THRESH  = 4;
    localparam int CNT_W   = 16;

    logic               clock;
    logic               reset;
    logic [NUM_MON-1:0] mon_block;
    logic [NUM_MON-1:0] mon_idle;
    logic               report_ready;
    logic               report_valid;
    logic [IDX_W-1:0]   report_idx;
    logic [31:0]        report_time;
    logic               block;

    aesl_deadlock_report_arbiter #(
        .NUM_MON (NUM_MON),
        .IDX_W   (IDX_W),
        .THRESH  (THRESH),
        .CNT_W   (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mon_block    (mon_block),
        .mon_idle     (mon_idle),
        .report_ready (report_ready),
        .report_valid (report_valid),
        .report_idx   (report_idx),
        .report_time  (report_time),
        .block        (block)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] blk;
        logic [3:0] idle;
        logic       rdy;
        logic       exp_valid;
        logic [1:0] exp_idx;
        logic       chk_idx;
        logic       exp_block;
        logic       chk_block;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge, then settle away from the edge before sampling/driving.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic void add(input logic rst, input logic [3:0] blk, input logic [3:0] idle,
                                input logic rdy, input logic ev, input logic [1:0] eidx,
                                input logic ci, input logic eb, input logic cb);
        vec_t v;
        v.rst = rst; v.blk = blk; v.idle = idle; v.rdy = rdy;
        v.exp_valid = ev; v.exp_idx = eidx; v.chk_idx = ci;
        v.exp_block = eb; v.chk_block = cb;
        vecs.push_back(v);
    endfunction

    logic [31:0] exp_time;
    logic [1:0]  held_idx;
    logic [31:0] held_time;

    initial begin
        reset        = 1'b1;
        mon_block    = '0;
        mon_idle     = '0;
        report_ready = 1'b0;

        // ---- reset state ----
        add(1, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, 1);
        add(1, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, 1);

        // ---- single confirm on monitor 2 ----
        for (int i = 0; i < 4; i++) add(0, 4'b0100, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 4'b0100, 4'b0000, 0, 1, 2, 1, 1, 1);   // report one edge after pending
        add(0, 4'b0000, 4'b0000, 0, 1, 2, 1, 1, 1);   // latched even though q dropped
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);   // handshake
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);

        // ---- short bursts (3 < THRESH) with counter clear in between ----
        for (int i = 0; i < 3; i++) add(0, 4'b0010, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b0010, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);

        // ---- idle instance never confirms ----
        for (int i = 0; i < 100; i++) add(0, 4'b0010, 4'b0010, 0, 0, 0, 0, 0, (i == 99));

        // ---- simultaneous confirm of 0,1,3 from rr_ptr=0 ----
        add(1, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 4'b1011, 4'b0000, 1, 0, 0, 0, 0, 0);
        add(0, 4'b1011, 4'b0000, 1, 1, 0, 1, 1, 1);
        add(0, 4'b1011, 4'b0000, 1, 0, 0, 0, 0, 0);
        add(0, 4'b1011, 4'b0000, 1, 1, 1, 1, 1, 1);
        add(0, 4'b1011, 4'b0000, 1, 0, 0, 0, 0, 0);
        add(0, 4'b1011, 4'b0000, 1, 1, 3, 1, 1, 1);
        add(0, 4'b1011, 4'b0000, 1, 0, 0, 0, 0, 0);
        // saturated counters must not re-confirm
        add(0, 4'b1011, 4'b0000, 1, 0, 0, 0, 0, 0);
        add(0, 4'b1011, 4'b0000, 1, 0, 0, 0, 0, 1);

        // ---- re-arm after a drop; rr_ptr wrapped to 0 so 0 goes before 3 ----
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 4'b1001, 4'b0000, 1, 0, 0, 0, 0, 0);
        add(0, 4'b1001, 4'b0000, 1, 1, 0, 1, 1, 1);
        add(0, 4'b1001, 4'b0000, 1, 0, 0, 0, 0, 0);
        add(0, 4'b1001, 4'b0000, 1, 1, 3, 1, 1, 1);
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 1);

        foreach (vecs[n]) begin
            reset        = vecs[n].rst;
            mon_block    = vecs[n].blk;
            mon_idle     = vecs[n].idle;
            report_ready = vecs[n].rdy;
            step();
            check($sformatf("vec%0d_valid", n), {31'd0, report_valid}, {31'd0, vecs[n].exp_valid});
            if (vecs[n].chk_idx)
                check($sformatf("vec%0d_idx", n), {30'd0, report_idx}, {30'd0, vecs[n].exp_idx});
            if (vecs[n].chk_block)
                check($sformatf("vec%0d_block", n), {31'd0, block}, {31'd0, vecs[n].exp_block});
            if (vecs[n].rst)
                check($sformatf("vec%0d_time", n), report_time, 32'd0);
        end

        // ---- stamp, hold while not ready, reset mid-report ----
        // Reset edge is cycle 0; q rises before edge 17, pending sets on edge
        // 20 and the report launches on edge 21 with the stamp value 20.
        reset        = 1'b1;
        mon_block    = '0;
        mon_idle     = '0;
        report_ready = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) step();
        mon_block = 4'b1000;
        for (int i = 0; i < 4; i++) step();
        check("ts_pre_valid", {31'd0, report_valid}, 32'd0);
        step();
`ifdef AESL_DEADLOCK_TIMESTAMP_EN
        exp_time = 32'd20;
`else
        exp_time = 32'd0;
`endif
        check("ts_valid", {31'd0, report_valid}, 32'd1);
        check("ts_idx", {30'd0, report_idx}, 32'd3);
        check("ts_time", report_time, exp_time);
        check("ts_block", {31'd0, block}, 32'd1);
        held_idx  = 2'd3;
        held_time = exp_time;
        mon_block = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("hold%0d_valid", i), {31'd0, report_valid}, 32'd1);
            check($sformatf("hold%0d_idx", i), {30'd0, report_idx}, {30'd0, held_idx});
            check($sformatf("hold%0d_time", i), report_time, held_time);
        end
        reset = 1'b1;
        step();
        check("rst_mid_valid", {31'd0, report_valid}, 32'd0);
        check("rst_mid_block", {31'd0, block}, 32'd0);
        check("rst_mid_idx", {30'd0, report_idx}, 32'd0);
        check("rst_mid_time", report_time, 32'd0);
        reset        = 1'b0;
        report_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("post_rst_valid", {31'd0, report_valid}, 32'd0);
        check("post_rst_block", {31'd0, block}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
